// File: rtl/fifo_flags_if.sv
// fifo_flags_if: write/read handshake, data and status bundle for fifo_flags.
interface fifo_flags_if #(parameter int DWIDTH = 8, parameter int DEPTH = 8);
  logic wr_en, rd_en;
  logic [DWIDTH-1:0] din, dout;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic [$clog2(DEPTH):0] count;
  modport master (output wr_en, rd_en, din,
                  input dout, empty, full, almost_full, almost_empty, overflow, underflow, count);
  modport slave (input wr_en, rd_en, din,
                 output dout, empty, full, almost_full, almost_empty, overflow, underflow, count);
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with occupancy/sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module fifo_flags #(
  parameter int DWIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic clk,
  input logic rst,
  fifo_flags_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, wr_ok, rd_ok, empty, full;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [DWIDTH-1:0] head;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign head = mem_q[rd_ptr_q[AW-1:0]];
  // Acceptance uses the flags registered at the start of the cycle.
  always_comb begin
    wr_ok = f.wr_en && !full;
    rd_ok = f.rd_en && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + CW'(1) : rd_ptr_q;
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    ovf_d = ovf_q | (f.wr_en & full);
    unf_d = unf_q | (f.rd_en & empty);
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_ptr_q[AW-1:0]] = f.din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef FIFO_FWFT_EN
  assign f.dout = empty ? '0 : head;
`else
  logic [DWIDTH-1:0] dout_q, dout_d;
  always_comb dout_d = rd_ok ? head : dout_q;
  always_ff @(posedge clk) dout_q <= rst ? '0 : dout_d;
  assign f.dout = dout_q;
`endif
  assign f.empty = empty;
  assign f.full = full;
  assign f.almost_full = count_q >= CW'(AF_LEVEL);
  assign f.almost_empty = count_q <= CW'(AE_LEVEL);
  assign f.count = count_q;
  assign f.overflow = ovf_q;
  assign f.underflow = unf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: table-driven fill/drain plus wrap, simultaneous and reset sequences, with a queue model.
module tb_fifo_flags;
  logic clk = 0, rst;
  always #5 clk = ~clk;
  fifo_flags_if #(.DWIDTH(8), .DEPTH(4)) bus ();
  fifo_flags #(.DWIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (.clk(clk), .rst(rst), .f(bus));
  typedef struct {bit wr; bit rd; logic [7:0] din; int cnt; bit e, f, af, ae, ov, un;} vec_t;
  vec_t vecs [10];
  int checks = 0, failures = 0;
  logic [7:0] mq [$];
  logic [7:0] sb [$];
  logic [7:0] hold;
  bit m_ov, m_un;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check_state();
    chk("count", 32'(bus.count), mq.size());
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.full), 32'(mq.size() == 4));
    chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= 3));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= 1));
    chk("overflow", 32'(bus.overflow), 32'(m_ov));
    chk("underflow", 32'(bus.underflow), 32'(m_un));
  endtask
  task automatic step(bit wr, bit rd, logic [7:0] d);
    bit wok, rok;
    wok = wr && mq.size() < 4;
    rok = rd && mq.size() > 0;
    m_ov |= wr && mq.size() == 4;
    m_un |= rd && mq.size() == 0;
    if (rok) sb.push_back(mq[0]);
`ifdef FIFO_FWFT_EN
    if (rok) chk("fwft_pop_dout", 32'(bus.dout), 32'(sb.pop_front()));
`endif
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din = d;
    @(posedge clk);
    #1;
    bus.wr_en = 0;
    bus.rd_en = 0;
    if (rok) void'(mq.pop_front());
    if (wok) mq.push_back(d);
`ifdef FIFO_FWFT_EN
    chk("fwft_dout", 32'(bus.dout), mq.size() > 0 ? 32'(mq[0]) : 32'h0);
`else
    if (rok) hold = sb.pop_front();
    chk("dout", 32'(bus.dout), 32'(hold));
`endif
    check_state();
  endtask
  task automatic do_reset(bit wr);
    rst = 1;
    bus.wr_en = wr;
    bus.din = 8'hEE;
    @(posedge clk);
    #1;
    rst = 0;
    bus.wr_en = 0;
    mq.delete();
    sb.delete();
    hold = 0;
    m_ov = 0;
    m_un = 0;
    check_state();
    chk("rst_dout", 32'(bus.dout), 32'h0);
  endtask
  initial begin
    rst = 1;
    bus.wr_en = 0;
    bus.rd_en = 0;
    bus.din = 0;
    vecs[0] = '{1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0};
    vecs[1] = '{1, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 0, 8'h33, 3, 0, 0, 1, 0, 0, 0};
    vecs[3] = '{1, 0, 8'h44, 4, 0, 1, 1, 0, 0, 0};
    vecs[4] = '{1, 0, 8'h55, 4, 0, 1, 1, 0, 1, 0};
    vecs[5] = '{0, 1, 8'h00, 3, 0, 0, 1, 0, 1, 0};
    vecs[6] = '{0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 0};
    vecs[7] = '{0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0};
    vecs[8] = '{0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 0};
    vecs[9] = '{0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 1};
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vecs[i].f));
      chk($sformatf("v%0d_af", i), 32'(bus.almost_full), 32'(vecs[i].af));
      chk($sformatf("v%0d_ae", i), 32'(bus.almost_empty), 32'(vecs[i].ae));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ov));
      chk($sformatf("v%0d_unf", i), 32'(bus.underflow), 32'(vecs[i].un));
    end
`ifndef FIFO_FWFT_EN
    chk("drain_dout_held", 32'(bus.dout), 32'h44);
`endif
    do_reset(0);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) step(1, 0, 8'(r * 3 + k));
      for (int k = 0; k < 3; k++) step(0, 1, 8'h0);
      chk($sformatf("wrap%0d_count", r), 32'(bus.count), 32'h0);
    end
    do_reset(0);
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 1, 8'hA3);
    chk("both_at2_count", 32'(bus.count), 32'd2);
    step(1, 0, 8'hA4);
    step(1, 0, 8'hA5);
    step(1, 1, 8'hA6);
    chk("both_full_count", 32'(bus.count), 32'd3);
    chk("both_full_ovf", 32'(bus.overflow), 32'd1);
    do_reset(1);
    chk("rst_mid_count", 32'(bus.count), 32'd0);
    chk("rst_mid_ovf", 32'(bus.overflow), 32'd0);
    step(1, 1, 8'hB1);
    chk("both_empty_count", 32'(bus.count), 32'd1);
    chk("both_empty_unf", 32'(bus.underflow), 32'd1);
    step(0, 1, 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: data width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 8: storage entries, a power of two >=2; all DEPTH entries usable.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1: write request.
REQ-008 SHALL have port rd_en, input, 1: read request (pop acknowledge in FWFT mode).
REQ-009 SHALL have port din, input, DWIDTH: write data.
REQ-010 SHALL have port dout, output, DWIDTH: read data.
REQ-011 SHALL have ports empty, full, almost_full, almost_empty: outputs, 1 bit each, occupancy flags.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 SHALL have ports overflow, underflow: outputs, 1 bit each, sticky error flags.

Function
REQ-014 SHALL accept a write iff wr_en && !full, storing din at the tail; a rejected write SHALL leave the memory and pointers unchanged.
REQ-015 SHALL accept a read iff rd_en && !empty, advancing the head; a rejected read SHALL leave the pointers and dout unchanged.
REQ-016 SHALL use read/write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit, and the pointers wrap modulo 2*DEPTH with no special-case logic.
REQ-017 SHALL decide acceptance from flags registered at the start of the cycle: when full and wr_en&&rd_en, only the read is accepted; when empty and wr_en&&rd_en, only the write is accepted.
REQ-018 SHALL update count by +1 (write only), -1 (read only), or 0 (both or neither accepted), never exceeding DEPTH nor going below 0.
REQ-019 SHALL derive the flags as: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-020 SHALL drive all flags and count from registered state only, with no combinational path from wr_en, rd_en or din.
REQ-021 SHALL set overflow on any cycle with wr_en && full, and SHALL hold it until rst.
REQ-022 SHALL set underflow on any cycle with rd_en && empty, and SHALL hold it until rst.
REQ-023 SHALL preserve FIFO ordering across any number of pointer wraps.

Reset
REQ-024 SHALL, on a clk edge with rst=1, clear both pointers, count, overflow and underflow, and set dout=0, giving empty=1, full=0, almost_full=0 and almost_empty=1.
REQ-025 SHALL give rst priority over wr_en and rd_en in the same cycle; in-flight data is discarded and the memory array is not cleared.

Configuration
REQ-026 SHALL use macro FIFO_FWFT_EN to select the read mode.
REQ-027 SHALL, without FIFO_FWFT_EN, register dout with the head entry on the edge of an accepted read (1-cycle latency), and hold dout otherwise.
REQ-028 SHALL, with FIFO_FWFT_EN, drive dout = head entry whenever !empty and dout = 0 when empty, so that rd_en pops the word already shown (0-cycle latency).
REQ-029 SHALL, in FWFT mode, show the first written word on dout in the cycle after its write edge, together with empty deasserting.

Verification (DEPTH=4, DWIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
REQ-030 SHALL cover fill: write 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at count 4; a 5th write of 0x55 is dropped and overflow=1.
REQ-031 SHALL cover drain: read 4x from full -> 0x11,0x22,0x33,0x44 in order (non-FWFT one cycle after each rd_en; FWFT on dout before each pop); then empty=1, and a further rd_en sets underflow=1 with dout unchanged.
REQ-032 SHALL cover wrap: 10 rounds of write 3 / read 3 with data 0x00..0x1D -> exact order preserved, count returns to 0 each round.
REQ-033 SHALL cover simultaneous events: at count=2, wr_en&&rd_en -> count stays 2; at full, both asserted -> count 3, write dropped, overflow=1; at empty, both asserted -> count 1, underflow=1.
REQ-034 SHALL cover reset mid-operation: rst with count=3 and wr_en=1 -> next cycle count=0, empty=1, overflow=0, underflow=0, dout=0.
